// File: rtl/fm_ch_seq.sv
// Per-sample channel scheduler: walks the attr RAM once per sample strobe, snapshots each
// channel with key-on/off edge detection and hands it to the operator pipeline via valid/ready.
module fm_ch_seq #(
  parameter int unsigned NUM_CH = 18,
  parameter int unsigned CH_W   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_stb,
  output logic [CH_W-1:0] ch_sel,
  input  logic            ch_kon,
  input  logic            ch_cnt,
  input  logic [2:0]      ch_fb,
  input  logic [2:0]      ch_block,
  input  logic [9:0]      ch_fnum,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [CH_W-1:0] op_ch,
  output logic            op_kon,
  output logic            op_kon_edge,
  output logic            op_koff_edge,
  output logic            op_cnt,
  output logic [2:0]      op_fb,
  output logic [2:0]      op_block,
  output logic [9:0]      op_fnum,
  output logic            busy,
  output logic            frame_done,
  output logic            overrun,
  input  logic            overrun_clr
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  state_e            r_state, w_state_d;
  logic [CH_W-1:0]   r_ch_sel;
  logic [NUM_CH-1:0] r_kon_prev;
  logic [CH_W-1:0]   r_op_ch;
  logic              r_op_kon, r_op_kon_edge, r_op_koff_edge, r_op_cnt;
  logic [2:0]        r_op_fb, r_op_block;
  logic [9:0]        r_op_fnum;
  logic              r_frame_done, r_overrun;
  logic              w_hs, w_last, w_busy, w_prev;

  assign w_busy = (r_state != StIdle);
  assign w_hs   = (r_state == StIssue) & op_ready;
  assign w_last = (r_ch_sel == LastCh);
  assign w_prev = r_kon_prev[r_ch_sel];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (sample_stb) w_state_d = StFetch;
      StFetch: w_state_d = StIssue;
      StIssue: if (op_ready) w_state_d = w_last ? StIdle : StFetch;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_ch_sel       <= '0;
      r_kon_prev     <= '0;
      r_op_ch        <= '0;
      r_op_kon       <= 1'b0;
      r_op_kon_edge  <= 1'b0;
      r_op_koff_edge <= 1'b0;
      r_op_cnt       <= 1'b0;
      r_op_fb        <= '0;
      r_op_block     <= '0;
      r_op_fnum      <= '0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_frame_done <= w_hs & w_last;
      // A strobe during a frame is dropped; setting beats a same-cycle clear.
      if (sample_stb && w_busy) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
      if (r_state == StFetch) begin
        r_op_ch                <= r_ch_sel;
        r_op_kon               <= ch_kon;
        r_op_kon_edge          <= ch_kon & ~w_prev;
        r_op_koff_edge         <= ~ch_kon & w_prev;
        r_op_cnt               <= ch_cnt;
        r_op_fb                <= ch_fb;
        r_op_block             <= ch_block;
        r_op_fnum              <= ch_fnum;
        r_kon_prev[r_ch_sel]   <= ch_kon;
      end
      if (w_hs) begin
        r_ch_sel <= w_last ? '0 : r_ch_sel + 1'b1;
      end
    end
  end

  assign ch_sel       = r_ch_sel;
  assign op_valid     = (r_state == StIssue);
  assign busy         = w_busy;
  assign op_ch        = r_op_ch;
  assign op_kon       = r_op_kon;
  assign op_kon_edge  = r_op_kon_edge;
  assign op_koff_edge = r_op_koff_edge;
  assign op_cnt       = r_op_cnt;
  assign op_fb        = r_op_fb;
  assign op_block     = r_op_block;
  assign op_fnum      = r_op_fnum;
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_fm_ch_seq.sv
// Directed bench for fm_ch_seq: behavioural attr RAM, per-frame snapshot capture and a table of
// expected snapshot records, plus hand sequences for stall, overrun, mid-frame write and reset.
module tb_fm_ch_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_stb;
  logic [4:0] ch_sel;
  logic       ch_kon, ch_cnt;
  logic [2:0] ch_fb, ch_block;
  logic [9:0] ch_fnum;
  logic       op_valid, op_ready;
  logic [4:0] op_ch;
  logic       op_kon, op_kon_edge, op_koff_edge, op_cnt;
  logic [2:0] op_fb, op_block;
  logic [9:0] op_fnum;
  logic       busy, frame_done, overrun, overrun_clr;

  logic       ram_kon[32];
  logic       ram_cnt[32];
  logic [2:0] ram_fb[32];
  logic [2:0] ram_blk[32];
  logic [9:0] ram_fnum[32];

  assign ch_kon   = ram_kon[ch_sel];
  assign ch_cnt   = ram_cnt[ch_sel];
  assign ch_fb    = ram_fb[ch_sel];
  assign ch_block = ram_blk[ch_sel];
  assign ch_fnum  = ram_fnum[ch_sel];

  fm_ch_seq #(.NUM_CH(18), .CH_W(5)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_stb   (sample_stb),
    .ch_sel       (ch_sel),
    .ch_kon       (ch_kon),
    .ch_cnt       (ch_cnt),
    .ch_fb        (ch_fb),
    .ch_block     (ch_block),
    .ch_fnum      (ch_fnum),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_ch        (op_ch),
    .op_kon       (op_kon),
    .op_kon_edge  (op_kon_edge),
    .op_koff_edge (op_koff_edge),
    .op_cnt       (op_cnt),
    .op_fb        (op_fb),
    .op_block     (op_block),
    .op_fnum      (op_fnum),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frm;
    int         ch;
    logic       kon;
    logic       on;
    logic       off;
    logic [9:0] fnum;
    logic [2:0] blk;
    logic       cnt;
    logic [2:0] fb;
  } vec_t;

  vec_t tbl[8];

  int         nvec = 0;
  int         nmis = 0;
  int         s_ch[32];
  logic       s_kon[32], s_on[32], s_off[32], s_cnt[32];
  logic [2:0] s_fb[32], s_blk[32];
  logic [9:0] s_fnum[32];
  int         done_cyc, nsnap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses the strobe now and runs until frame_done; returns in the frame_done cycle.
  task automatic run_frame(input int stall_ch, input int ovr_at, input int clr_at,
                           input bit wr_ch1, output int dcyc, output int ns);
    int          cyc;
    int          stall;
    logic [22:0] held;
    sample_stb = 1'b1;
    op_ready   = 1'b1;
    tick();
    sample_stb = 1'b0;
    cyc   = 1;
    ns    = 0;
    dcyc  = -1;
    stall = 0;
    held  = '0;
    while (cyc < 200) begin
      if (frame_done) begin
        dcyc = cyc;
        break;
      end
      sample_stb  = (cyc == ovr_at);
      overrun_clr = (cyc == clr_at);
      op_ready    = 1'b1;
      if (op_valid) begin
        if (op_ch == 5'(stall_ch) && stall < 10) begin
          op_ready = 1'b0;
          if (stall == 0) begin
            held = {op_ch, op_kon, op_cnt, op_fb, op_block, op_fnum};
          end else begin
            chk("stall_stable", 32'({op_ch, op_kon, op_cnt, op_fb, op_block, op_fnum}),
                32'(held));
            chk("stall_valid", 32'(op_valid), 32'd1);
          end
          stall++;
        end
        if (wr_ch1 && op_ch == 5'd1) begin
          ram_fnum[2] = 10'h100;
          ram_fnum[0] = 10'h3FF;
        end
        if (op_ready && ns < 32) begin
          s_ch[ns]   = int'(op_ch);
          s_kon[ns]  = op_kon;
          s_on[ns]   = op_kon_edge;
          s_off[ns]  = op_koff_edge;
          s_cnt[ns]  = op_cnt;
          s_fb[ns]   = op_fb;
          s_blk[ns]  = op_block;
          s_fnum[ns] = op_fnum;
          ns++;
        end
      end
      tick();
      cyc++;
    end
    sample_stb  = 1'b0;
    overrun_clr = 1'b0;
    if (dcyc < 0) begin
      nvec++;
      nmis++;
      $display("FAIL frame_timeout: got no frame_done expected one within 200 cycles");
    end
  endtask

  task automatic check_frame(input int frm, input int exp_done);
    chk("frame_done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("snapshot_count", 32'(nsnap), 32'd18);
    for (int i = 0; i < 18; i++) chk("channel_order", 32'(s_ch[i]), 32'(i));
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].frm == frm) begin
        chk("tbl_kon",   32'(s_kon[tbl[t].ch]),  32'(tbl[t].kon));
        chk("tbl_on",    32'(s_on[tbl[t].ch]),   32'(tbl[t].on));
        chk("tbl_off",   32'(s_off[tbl[t].ch]),  32'(tbl[t].off));
        chk("tbl_fnum",  32'(s_fnum[tbl[t].ch]), 32'(tbl[t].fnum));
        chk("tbl_block", 32'(s_blk[tbl[t].ch]),  32'(tbl[t].blk));
        chk("tbl_cnt",   32'(s_cnt[tbl[t].ch]),  32'(tbl[t].cnt));
        chk("tbl_fb",    32'(s_fb[tbl[t].ch]),   32'(tbl[t].fb));
      end
    end
  endtask

  initial begin
    bit found;
    tbl[0] = '{1,  0, 1'b0, 1'b0, 1'b0, 10'h005, 3'd0, 1'b0, 3'd3};
    tbl[1] = '{1,  5, 1'b1, 1'b1, 1'b0, 10'h2A5, 3'd4, 1'b1, 3'd0};
    tbl[2] = '{1, 17, 1'b0, 1'b0, 1'b0, 10'h27A, 3'd1, 1'b1, 3'd4};
    tbl[3] = '{2,  5, 1'b1, 1'b0, 1'b0, 10'h2A5, 3'd4, 1'b1, 3'd0};
    tbl[4] = '{3,  5, 1'b0, 1'b0, 1'b1, 10'h2A5, 3'd4, 1'b1, 3'd0};
    tbl[5] = '{3,  6, 1'b0, 1'b0, 1'b0, 10'h0E3, 3'd6, 1'b0, 3'd1};
    tbl[6] = '{9,  5, 1'b1, 1'b1, 1'b0, 10'h2A5, 3'd4, 1'b1, 3'd0};
    tbl[7] = '{10, 5, 1'b1, 1'b1, 1'b0, 10'h2A5, 3'd4, 1'b1, 3'd0};

    for (int i = 0; i < 32; i++) begin
      ram_kon[i]  = 1'b0;
      ram_cnt[i]  = 1'(i & 1);
      ram_fb[i]   = 3'((i + 3) % 8);
      ram_blk[i]  = 3'(i % 8);
      ram_fnum[i] = 10'(i * 37 + 5);
    end
    ram_kon[5]  = 1'b1;
    ram_fnum[5] = 10'h2A5;
    ram_blk[5]  = 3'd4;

    reset_n     = 1'b0;
    sample_stb  = 1'b0;
    op_ready    = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ch_sel", 32'(ch_sel), 32'd0);
    chk("rst_op_fields", 32'({op_ch, op_kon, op_kon_edge, op_koff_edge, op_fnum}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Frames 1 and 2 run back to back: the second strobe lands in the frame_done cycle.
    run_frame(-1, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(1, 37);
    run_frame(-1, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(2, 37);
    chk("no_overrun_on_done_stb", 32'(overrun), 32'd0);
    for (int i = 0; i < 18; i++) chk("steady_no_edges", 32'({s_on[i], s_off[i]}), 32'd0);

    ram_kon[5] = 1'b0;
    run_frame(-1, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(3, 37);
    for (int i = 0; i < 18; i++) begin
      if (i != 5) chk("koff_only_ch5", 32'(s_off[i]), 32'd0);
    end

    run_frame(3, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(4, 47);

    run_frame(-1, 10, -1, 1'b0, done_cyc, nsnap);
    check_frame(5, 37);
    chk("overrun_set", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'd0);

    run_frame(-1, 10, 10, 1'b0, done_cyc, nsnap);
    check_frame(6, 37);
    chk("overrun_set_beats_clr", 32'(overrun), 32'd1);

    run_frame(-1, -1, -1, 1'b1, done_cyc, nsnap);
    check_frame(7, 37);
    chk("write_before_fetch", 32'(s_fnum[2]), 32'h100);
    chk("write_after_fetch_old", 32'(s_fnum[0]), 32'h005);
    run_frame(-1, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(8, 37);
    chk("write_after_fetch_next", 32'(s_fnum[0]), 32'h3FF);
    tick();
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);

    ram_kon[5] = 1'b1;
    run_frame(-1, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(9, 37);

    // Reset while ch9 is waiting for acceptance; ch5 history is 1 at that point.
    sample_stb = 1'b1;
    op_ready   = 1'b1;
    tick();
    sample_stb = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (op_valid && op_ch == 5'd9) begin
        found    = 1'b1;
        op_ready = 1'b0;
      end else begin
        tick();
      end
    end
    chk("reached_ch9", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_op_valid", 32'(op_valid), 32'd0);
    chk("async_rst_ch_sel", 32'(ch_sel), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run_frame(-1, -1, -1, 1'b0, done_cyc, nsnap);
    check_frame(10, 37);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
